// File: rtl/alu_seq_pkg.sv
// Shared op-code constants, FSM state encoding and small helpers for alu_seq.
package alu_seq_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_OR  = 4'd0,
      OP_AND = 4'd1,
      OP_NOT = 4'd2,
      OP_ADD = 4'd3,
      OP_SUB = 4'd4,
      OP_NEG = 4'd5,
      OP_MUL = 4'd6,
      OP_DIV = 4'd7,
      OP_SHL = 4'd8,
      OP_SHR = 4'd9,
      OP_SRA = 4'd10,
      OP_ROL = 4'd11,
      OP_ROR = 4'd12
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } state_e;

   // True for the ops that take the multi-cycle MUL/DIV path.
   function automatic logic is_iterative(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
module alu_seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH:0]   shifted_c;
   logic [WIDTH:0]   trial_c;

   // Shift in the next dividend bit and trial-subtract the divisor.
   always_comb begin
      shifted_c = {remainder, quotient[WIDTH-1]};
      trial_c   = shifted_c - (WIDTH+1)'(dvs_q);
   end

   // Quotient register doubles as the dividend shift register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         quotient  <= '0;
         remainder <= '0;
         dvs_q     <= '0;
      end else if (load) begin
         quotient  <= dividend;
         remainder <= '0;
         dvs_q     <= divisor;
      end else if (step) begin
         if (!trial_c[WIDTH]) begin
            remainder <= trial_c[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b1};
         end else begin
            remainder <= shifted_c[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/and_or.sv
// Bitwise OR/AND of two operands, shared by the single-cycle logic ops.
module and_or #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] or_y_c,
   output logic [WIDTH-1:0] and_y_c
);

   // Pure combinational bitwise results.
   always_comb begin
      or_y_c  = a | b;
      and_y_c = a & b;
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative signed MUL/DIV.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);

   state_e             state, state_nxt;
   logic               busy_nxt, done_nxt;
   logic               accept_c;
   logic [SHW-1:0]     cnt;
   logic [SHW-1:0]     amt_c;
   logic [WIDTH-1:0]   mag_a_c, mag_b_c;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   acc_hi, acc_lo;
   logic [WIDTH:0]     mul_sum_c;
   logic [2*WIDTH-1:0] mul_prod_c;
   logic               sign_a, sign_b, is_div, b_zero;
   logic [WIDTH-1:0]   or_c, and_c, alu_lo_c;
   logic [WIDTH-1:0]   quo, rem;

   assign accept_c   = (state == ST_IDLE) && start;
   assign amt_c      = B[SHW-1:0];
   assign mag_a_c    = A[WIDTH-1] ? -A : A;
   assign mag_b_c    = B[WIDTH-1] ? -B : B;
   assign mul_sum_c  = (WIDTH+1)'(acc_hi) + (acc_lo[0] ? (WIDTH+1)'(opnd_q) : '0);
   assign mul_prod_c = {acc_hi, acc_lo};

   and_or #(.WIDTH(WIDTH)) u_and_or (
      .a       (A),
      .b       (B),
      .or_y_c  (or_c),
      .and_y_c (and_c)
   );

   alu_seq_divider #(.WIDTH(WIDTH)) u_divider (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (accept_c && (op == OP_DIV)),
      .step      (state == ST_DIV),
      .dividend  (mag_a_c),
      .divisor   (mag_b_c),
      .quotient  (quo),
      .remainder (rem)
   );

   // State register plus registered busy/done flags.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state: one MUL/DIV cycle per operand bit, then FIX, then DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (op == OP_MUL)      state_nxt = ST_MUL;
               else if (op == OP_DIV) state_nxt = ST_DIV;
               else                   state_nxt = ST_DONE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (cnt == SHW'(WIDTH - 1)) state_nxt = ST_FIX;
         end
         ST_FIX:  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so busy/done come straight from flops.
   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      case (state_nxt)
         ST_MUL, ST_DIV, ST_FIX: busy_nxt = 1'b1;
         ST_DONE:                done_nxt = 1'b1;
         default: ;
      endcase
   end

   // Single-cycle op results; unlisted codes fall through to AND.
   always_comb begin
      alu_lo_c = and_c;
      case (op)
         OP_OR:   alu_lo_c = or_c;
         OP_AND:  alu_lo_c = and_c;
         OP_NOT:  alu_lo_c = ~A;
         OP_ADD:  alu_lo_c = A + B;
         OP_SUB:  alu_lo_c = A - B;
         OP_NEG:  alu_lo_c = -A;
         OP_SHL:  alu_lo_c = A << amt_c;
         OP_SHR:  alu_lo_c = A >> amt_c;
         OP_SRA:  alu_lo_c = $signed(A) >>> amt_c;
         OP_ROL:  alu_lo_c = (A << amt_c) | (A >> (WIDTH - 32'(amt_c)));
         OP_ROR:  alu_lo_c = (A >> amt_c) | (A << (WIDTH - 32'(amt_c)));
         default: alu_lo_c = and_c;
      endcase
   end

   // Operand capture, shift-add multiply loop, sign fix-up and result hold.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt         <= '0;
         opnd_q      <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         is_div      <= 1'b0;
         b_zero      <= 1'b0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cnt    <= '0;
                  sign_a <= A[WIDTH-1];
                  sign_b <= B[WIDTH-1];
                  is_div <= (op == OP_DIV);
                  b_zero <= (B == '0);
                  // MUL keeps |A| as multiplicand; DIV keeps raw A for the B=0 result.
                  opnd_q <= (op == OP_DIV) ? A : mag_a_c;
                  acc_hi <= '0;
                  acc_lo <= mag_b_c;
                  if (!is_iterative(op)) begin
                     result_hi   <= '0;
                     result_lo   <= alu_lo_c;
                     div_by_zero <= 1'b0;
                  end
               end
            end
            ST_MUL: begin
               {acc_hi, acc_lo} <= {mul_sum_c, acc_lo[WIDTH-1:1]};
               cnt              <= cnt + SHW'(1);
            end
            ST_DIV: begin
               cnt <= cnt + SHW'(1);
            end
            ST_FIX: begin
               if (is_div) begin
                  if (b_zero) begin
                     result_lo   <= '1;
                     result_hi   <= opnd_q;
                     div_by_zero <= 1'b1;
                  end else begin
                     result_lo   <= (sign_a ^ sign_b) ? -quo : quo;
                     result_hi   <= sign_a ? -rem : rem;
                     div_by_zero <= 1'b0;
                  end
               end else begin
                  {result_hi, result_lo} <= (sign_a ^ sign_b) ? -mul_prod_c : mul_prod_c;
                  div_by_zero            <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start32, start8;
   logic [3:0]  op_in;
   logic [31:0] a_in, b_in;
   logic        busy32, done32, dbz32;
   logic [31:0] hi32, lo32;
   logic        busy8, done8, dbz8;
   logic [7:0]  hi8, lo8;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clock = ~clock;

   alu_seq #(.WIDTH(32)) u_dut32 (
      .clock(clock), .reset_n(reset_n), .start(start32), .op(op_in),
      .A(a_in), .B(b_in), .busy(busy32), .done(done32),
      .result_hi(hi32), .result_lo(lo32), .div_by_zero(dbz32)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clock(clock), .reset_n(reset_n), .start(start8), .op(op_in),
      .A(a_in[7:0]), .B(b_in[7:0]), .busy(busy8), .done(done8),
      .result_hi(hi8), .result_lo(lo8), .div_by_zero(dbz8)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs [0:12];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on w-bit two's complement values.
   function automatic void model(input int w, input int op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
      logic [63:0] ua, ub, mask, r, t;
      longint      sa, sb, p, q, rm;
      int          n;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, a} & mask;
      ub   = {32'd0, b} & mask;
      sa   = $signed(ua);
      sb   = $signed(ub);
      if (ua[w-1]) sa = sa - (longint'(1) << w);
      if (ub[w-1]) sb = sb - (longint'(1) << w);
      n    = int'(ub[5:0]) % w;
      hi   = 32'd0;
      dbz  = 1'b0;
      r    = 64'd0;
      case (op)
         0:  r = ua | ub;
         1:  r = ua & ub;
         2:  r = ~ua;
         3:  r = ua + ub;
         4:  r = ua - ub;
         5:  r = -ua;
         6: begin
            p  = sa * sb;
            r  = p;
            hi = 32'((r >> w) & mask);
         end
         7: begin
            if (sb == 0) begin
               r   = mask;
               hi  = 32'(ua);
               dbz = 1'b1;
            end else begin
               q  = sa / sb;
               rm = sa % sb;
               r  = q;
               t  = rm;
               hi = 32'(t & mask);
            end
         end
         8:  r = ua << n;
         9:  r = ua >> n;
         10: begin p = sa >>> n; r = p; end
         11: r = (ua << n) | (ua >> (w - n));
         12: r = (ua >> n) | (ua << (w - n));
         default: r = ua & ub;
      endcase
      lo = 32'(r & mask);
   endfunction

   // Issue one op to the selected DUT and wait (bounded) for done.
   task automatic run(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                      output int lat, output logic flags_ok);
      logic d, bz;
      @(negedge clock);
      op_in = op;
      a_in  = a;
      b_in  = b;
      if (w == 32) start32 = 1'b1; else start8 = 1'b1;
      lat      = 0;
      d        = 1'b0;
      flags_ok = 1'b1;
      while (!d && lat < 200) begin
         @(posedge clock);
         #1;
         if (lat == 0) begin
            start32 = 1'b0;
            start8  = 1'b0;
            a_in    = $urandom;
            b_in    = $urandom;
         end
         lat++;
         d  = (w == 32) ? done32 : done8;
         bz = (w == 32) ? busy32 : busy8;
         if (bz === d) flags_ok = 1'b0;
      end
      hi  = (w == 32) ? hi32 : {24'd0, hi8};
      lo  = (w == 32) ? lo32 : {24'd0, lo8};
      dbz = (w == 32) ? dbz32 : dbz8;
      @(posedge clock);
      #1;
      if (((w == 32) ? done32 : done8) !== 1'b0) flags_ok = 1'b0;
   endtask

   initial begin
      logic [31:0] hi, lo, ehi, elo;
      logic        dbz, edbz, fok, saw_done;
      int          lat, done_cnt, done_at, w, opr;
      logic [31:0] a, b, mask;

      reset_n = 1'b0;
      start32 = 1'b0;
      start8  = 1'b0;
      op_in   = 4'd0;
      a_in    = 32'd0;
      b_in    = 32'd0;

      vecs[0]  = '{4'd3,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        1'b0, 1};
      vecs[1]  = '{4'd6,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
      vecs[2]  = '{4'd7,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
      vecs[3]  = '{4'd7,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 34};
      vecs[4]  = '{4'd12, 32'h00000001, 32'h21,       32'h0,        32'h80000000, 1'b0, 1};
      vecs[5]  = '{4'd10, 32'h80000000, 32'd31,       32'h0,        32'hFFFFFFFF, 1'b0, 1};
      vecs[6]  = '{4'd7,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 34};
      vecs[7]  = '{4'd8,  32'h12345678, 32'h20,       32'h0,        32'h12345678, 1'b0, 1};
      vecs[8]  = '{4'd13, 32'h0000F0F0, 32'h0000FF00, 32'h0,        32'h0000F000, 1'b0, 1};
      vecs[9]  = '{4'd4,  32'd0,        32'd1,        32'h0,        32'hFFFFFFFF, 1'b0, 1};
      vecs[10] = '{4'd6,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 34};
      vecs[11] = '{4'd7,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
      vecs[12] = '{4'd5,  32'h80000000, 32'd0,        32'h0,        32'h80000000, 1'b0, 1};

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("reset_busy32", {63'd0, busy32}, 64'd0);
      check("reset_done32", {63'd0, done32}, 64'd0);
      check("reset_res32", {hi32, lo32}, 64'd0);
      check("reset_dbz32", {63'd0, dbz32}, 64'd0);
      check("reset_res8", {48'd0, hi8, lo8}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Directed table, WIDTH=32
      for (int i = 0; i <= 12; i++) begin
         run(32, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dbz, lat, fok);
         check($sformatf("vec%0d_result", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
         check($sformatf("vec%0d_dbz", i), {63'd0, dbz}, {63'd0, vecs[i].dbz});
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("vec%0d_busy_done", i), {63'd0, fok}, 64'd1);
      end

      // Results hold after done
      repeat (3) @(posedge clock);
      #1;
      check("hold_result", {hi32, lo32}, {32'h0, 32'h80000000});

      // Start while busy is ignored and not queued
      @(negedge clock);
      op_in   = 4'd6;
      a_in    = 32'd1234;
      b_in    = 32'hFFFFFFFB;
      start32 = 1'b1;
      done_cnt = 0;
      done_at  = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock);
         #1;
         start32 = 1'b0;
         if (done32) begin
            done_cnt++;
            if (done_at == 0) done_at = c;
         end
         if (c == 5) begin
            op_in   = 4'd3;
            a_in    = 32'd1;
            b_in    = 32'd1;
            start32 = 1'b1;
         end
      end
      check("noqueue_done_count", 64'(done_cnt), 64'd1);
      check("noqueue_done_cycle", 64'(done_at), 64'd34);
      check("noqueue_result", {hi32, lo32}, {32'hFFFFFFFF, 32'hFFFFE7E6});

      // Reset in the middle of MUL aborts without done
      @(negedge clock);
      op_in    = 4'd6;
      a_in     = 32'd9;
      b_in     = 32'd9;
      start32  = 1'b1;
      saw_done = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(posedge clock);
         #1;
         start32 = 1'b0;
         if (done32) saw_done = 1'b1;
         if (c == 5) begin
            check("abort_busy_c5", {63'd0, busy32}, 64'd1);
            check("abort_hold_c5", {hi32, lo32}, {32'hFFFFFFFF, 32'hFFFFE7E6});
            op_in   = 4'd3;
            start32 = 1'b1;
         end
         if (c == 10) reset_n = 1'b0;
      end
      check("abort_no_done", {63'd0, saw_done}, 64'd0);
      check("abort_outputs", {29'd0, busy32, done32, dbz32, hi32, lo32}, 64'd0);
      check("abort_outputs8", {46'd0, busy8, done8, hi8, lo8}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Randomized regression against the reference model at both widths
      for (int k = 0; k < 400; k++) begin
         w    = (k < 200) ? 32 : 8;
         mask = (w == 32) ? 32'hFFFFFFFF : 32'h000000FF;
         opr  = int'($urandom_range(0, 15));
         a    = $urandom & mask;
         b    = $urandom & mask;
         case ($urandom_range(0, 7))
            0: begin a = 32'h1 << (w - 1); b = mask; end
            1: b = 32'd0;
            2: b = 32'($urandom_range(0, 2 * w)) & mask;
            default: ;
         endcase
         if (k == 0) begin opr = 7; a = 32'h80000000; b = 32'hFFFFFFFF; end
         model(w, opr, a, b, ehi, elo, edbz);
         run(w, 4'(opr), a, b, hi, lo, dbz, lat, fok);
         check($sformatf("rnd%0d_w%0d_op%0d_result", k, w, opr), {hi, lo}, {ehi, elo});
         check($sformatf("rnd%0d_w%0d_op%0d_dbz", k, w, opr), {63'd0, dbz}, {63'd0, edbz});
         check($sformatf("rnd%0d_w%0d_op%0d_latency", k, w, opr), 64'(lat),
               64'((opr == 6 || opr == 7) ? w + 2 : 1));
         check($sformatf("rnd%0d_w%0d_op%0d_busy_done", k, w, opr), {63'd0, fok}, 64'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
